// File: rtl/instr_fetch_buffer.sv
// ----------------------------------------------------------------------------
// instr_fetch_buffer
//
// Dual-issue instruction queue sitting between fetch and the two decode
// slots. Fetch pushes up to two {pc, instr} pairs per cycle and decode pops up
// to two. The two oldest entries are always presented in program order. A
// synchronous flush empties the queue on a branch redirect.
//
// Ports
//   clk                    rising-edge clock
//   reset                  asynchronous, active-high
//   flush                  synchronous queue clear (highest priority)
//   in_valid[1:0]          fetch push request; bit1 only counts with bit0
//   in_instr0/in_pc0       older fetched instruction and its PC
//   in_instr1/in_pc1       younger fetched instruction and its PC
//   in_ready               at least two free entries
//   out_valid[1:0]         bit0: >=1 entry held, bit1: >=2 entries held
//   out_instr0/out_pc0     oldest entry (NOP / 0 when not valid)
//   out_instr1/out_pc1     second-oldest entry (NOP / 0 when not valid)
//   out_take[1:0]          decode pop; bit1 only counts with bit0
//   count                  entries currently held
// ----------------------------------------------------------------------------
module instr_fetch_buffer #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [1:0]               in_valid,
    input  logic [XLEN-1:0]          in_instr0,
    input  logic [XLEN-1:0]          in_pc0,
    input  logic [XLEN-1:0]          in_instr1,
    input  logic [XLEN-1:0]          in_pc1,
    output logic                     in_ready,
    output logic [1:0]               out_valid,
    output logic [XLEN-1:0]          out_instr0,
    output logic [XLEN-1:0]          out_pc0,
    output logic [XLEN-1:0]          out_instr1,
    output logic [XLEN-1:0]          out_pc1,
    input  logic [1:0]               out_take,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // addi x0,x0,0 -- what an empty decode slot sees, so the Extend unit and
    // register-file reads downstream act on a harmless instruction.
    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

    // Pointers carry one extra MSB so full and empty are distinguishable;
    // they wrap naturally modulo 2*DEPTH.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;

    logic [1:0]    push_n;
    logic [1:0]    pop_n;

    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];

    logic            wr_en    [2];
    logic [AW-1:0]   wr_addr  [2];
    logic [XLEN-1:0] wr_instr [2];
    logic [XLEN-1:0] wr_pc    [2];

    logic [XLEN-1:0] head_instr [2];
    logic [XLEN-1:0] head_pc    [2];

    // in_ready looks only at the registered count; a same-cycle pop does not
    // make room for a push.
    assign in_ready = (count_q <= PW'(DEPTH - 2));

    always_comb begin
        push_n = 2'd0;
        if (in_ready && in_valid[0]) begin
            push_n = in_valid[1] ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        pop_n = 2'd0;
        if (out_take[0] && out_valid[0]) begin
            pop_n = (out_take[1] && out_valid[1]) ? 2'd2 : 2'd1;
        end
    end

    assign wr_instr[0] = in_instr0;
    assign wr_instr[1] = in_instr1;
    assign wr_pc[0]    = in_pc0;
    assign wr_pc[1]    = in_pc1;

    // Per-slot write port (slot0 -> wr_ptr, slot1 -> wr_ptr+1) and per-slot
    // head view (slot0 <- rd_ptr, slot1 <- rd_ptr+1).
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        logic [AW-1:0] rd_addr;

        assign wr_en[gi]   = !flush && (push_n > 2'(gi));
        assign wr_addr[gi] = AW'(wr_ptr_q + PW'(gi));

        assign rd_addr        = AW'(rd_ptr_q + PW'(gi));
        assign out_valid[gi]  = (count_q > PW'(gi));
        assign head_instr[gi] = out_valid[gi] ? instr_mem_q[rd_addr] : NOP_INSTR;
        assign head_pc[gi]    = out_valid[gi] ? pc_mem_q[rd_addr]    : '0;
    end

    assign out_instr0 = head_instr[0];
    assign out_pc0    = head_pc[0];
    assign out_instr1 = head_instr[1];
    assign out_pc1    = head_pc[1];
    assign count      = count_q;

    // Storage has no reset: stale contents are never visible because the
    // head view is gated by count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_en[i]) begin
                instr_mem_q[wr_addr[i]] <= wr_instr[i];
                pc_mem_q[wr_addr[i]]    <= wr_pc[i];
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_n);
        rd_ptr_d = rd_ptr_q + PW'(pop_n);
        count_d  = count_q + PW'(push_n) - PW'(pop_n);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_buffer
//
// Directed bench for instr_fetch_buffer. The driver issues one transaction
// per falling edge and enqueues the {pc, instr} pairs it expects to be
// accepted. A separate monitor samples the outputs shortly before each rising
// edge, compares the head slots against the front of the queue and the
// occupancy flags against the queue depth, and retires whatever decode takes.
// ----------------------------------------------------------------------------
module tb_instr_fetch_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [1:0]  in_valid = 2'b00;
    logic [31:0] in_instr0 = '0, in_pc0 = '0, in_instr1 = '0, in_pc1 = '0;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [31:0] out_instr0, out_pc0, out_instr1, out_pc1;
    logic [1:0]  out_take = 2'b00;
    logic [3:0]  count;

    int n_checks = 0;
    int n_pass   = 0;
    int pend_n   = 0;           // entries enqueued for the upcoming edge
    logic [63:0] sb_q[$];       // expected entries, {pc, instr}, oldest first

    instr_fetch_buffer #(.DEPTH(8), .XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_instr0  (in_instr0),
        .in_pc0     (in_pc0),
        .in_instr1  (in_instr1),
        .in_pc1     (in_pc1),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_instr0 (out_instr0),
        .out_pc0    (out_pc0),
        .out_instr1 (out_instr1),
        .out_pc1    (out_pc1),
        .out_take   (out_take),
        .count      (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return 32'h0000_0093 ^ {pc[15:0], 16'h0000};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One transaction per cycle; acc says whether the push is expected to be
    // accepted (worked out by hand for each vector).
    task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] i0,
                         input logic [31:0] p1, input logic [31:0] i1,
                         input logic [1:0] take, input logic fl, input logic acc);
        @(negedge clk);
        in_valid  = v;
        in_pc0    = p0;
        in_instr0 = i0;
        in_pc1    = p1;
        in_instr1 = i1;
        out_take  = take;
        flush     = fl;
        pend_n    = 0;
        if (acc && v[0]) begin
            sb_q.push_back({p0, i0});
            pend_n = 1;
            if (v[1]) begin
                sb_q.push_back({p1, i1});
                pend_n = 2;
            end
        end
        $display("drive: valid=%b pc0=%h pc1=%h take=%b flush=%b accept=%0d",
                 v, p0, p1, take, fl, pend_n);
    endtask

    task automatic idle();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic push2(input logic [31:0] pc);
        drive(2'b11, pc, mk(pc), pc + 32'd4, mk(pc + 32'd4), 2'b00, 1'b0, 1'b1);
    endtask

    task automatic take(input logic [1:0] t);
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, t, 1'b0, 1'b0);
    endtask

    // Monitor: compare, then retire what decode takes this cycle.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                sb_q.delete();
            end else begin
                int cnt;
                int pops;
                cnt = sb_q.size() - pend_n;
                check("count", 64'(count), 64'(cnt));
                check("in_ready", 64'(in_ready), 64'(cnt <= 6));
                check("out_valid", 64'(out_valid), 64'({cnt >= 2, cnt >= 1}));
                if (cnt >= 1) check("slot0", {out_pc0, out_instr0}, sb_q[0]);
                else          check("slot0_nop", {out_pc0, out_instr0}, {32'h0, NOP});
                if (cnt >= 2) check("slot1", {out_pc1, out_instr1}, sb_q[1]);
                else          check("slot1_nop", {out_pc1, out_instr1}, {32'h0, NOP});
                pops = 0;
                if (out_take[0] && cnt >= 1) pops = (out_take[1] && cnt >= 2) ? 2 : 1;
                if (flush) begin
                    $display("monitor: flush, %0d entries discarded", cnt);
                    sb_q.delete();
                end else begin
                    for (int k = 0; k < pops; k++) begin
                        logic [63:0] e;
                        e = sb_q.pop_front();
                        $display("monitor: pop pc=%h instr=%h", e[63:32], e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: first pair appears the cycle after the push edge
        drive(2'b11, 32'h0, 32'h0050_0093, 32'h4, 32'h00A0_0113, 2'b00, 1'b0, 1'b1);
        idle();
        #3;
        check("t1_out_valid", 64'(out_valid), 64'(2'b11));
        check("t1_out_instr0", 64'(out_instr0), 64'(32'h0050_0093));
        check("t1_out_pc1", 64'(out_pc1), 64'(32'h4));
        check("t1_count", 64'(count), 64'd2);

        // 2: fill to 7, then pushes while not ready are dropped
        push2(32'h8);
        push2(32'h10);
        drive(2'b01, 32'h18, mk(32'h18), 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);
        idle();
        #3;
        check("t2_in_ready", 64'(in_ready), 64'd0);
        check("t2_count", 64'(count), 64'd7);
        drive(2'b11, 32'h1C, mk(32'h1C), 32'h20, mk(32'h20), 2'b00, 1'b0, 1'b0);
        drive(2'b11, 32'h1C, mk(32'h1C), 32'h20, mk(32'h20), 2'b00, 1'b0, 1'b0);
        idle();
        #3;
        check("t2_count_held", 64'(count), 64'd7);
        check("t2_head", 64'(out_pc0), 64'h0);
        take(2'b11);
        take(2'b11);

        // 3: count 3, push 2 + take 2 across the array wrap
        drive(2'b11, 32'h1C, mk(32'h1C), 32'h20, mk(32'h20), 2'b11, 1'b0, 1'b1);
        idle();
        #3;
        check("t3_count", 64'(count), 64'd3);
        check("t3_head", 64'(out_pc0), 64'h18);
        take(2'b11);
        idle();
        #3;
        check("t3_wrap_head", 64'(out_pc0), 64'h20);
        check("t3_wrap_count", 64'(count), 64'd1);

        // 4: take 11 with one entry pops only one
        take(2'b11);
        idle();
        #3;
        check("t4_count", 64'(count), 64'd0);
        check("t4_out_valid", 64'(out_valid), 64'(2'b00));
        check("t4_out_instr0", 64'(out_instr0), 64'(NOP));

        // 5: flush wins over same-cycle push and pop
        push2(32'h24);
        push2(32'h2C);
        drive(2'b01, 32'h34, mk(32'h34), 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);
        drive(2'b11, 32'h40, mk(32'h40), 32'h44, mk(32'h44), 2'b01, 1'b1, 1'b0);
        idle();
        #3;
        check("t5_count", 64'(count), 64'd0);
        check("t5_out_valid", 64'(out_valid), 64'(2'b00));
        check("t5_in_ready", 64'(in_ready), 64'd1);
        drive(2'b01, 32'h100, mk(32'h100), 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);
        idle();
        #3;
        check("t5_new_head", {out_pc0, out_instr0}, {32'h100, mk(32'h100)});
        check("t5_new_valid", 64'(out_valid), 64'(2'b01));
        take(2'b01);

        // 6: async reset mid-cycle with 4 entries held
        push2(32'h200);
        push2(32'h208);
        idle();
        #1;
        reset = 1'b1;
        #1;
        check("t6_out_valid", 64'(out_valid), 64'(2'b00));
        check("t6_in_ready", 64'(in_ready), 64'd1);
        check("t6_count", 64'(count), 64'd0);
        check("t6_slot0", {out_pc0, out_instr0}, {32'h0, NOP});
        check("t6_slot1", {out_pc1, out_instr1}, {32'h0, NOP});
        drive(2'b10, 32'h300, mk(32'h300), 32'h304, mk(32'h304), 2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        idle();
        #3;
        check("t6_no_push", 64'(count), 64'd0);

        idle();
        idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
